escalonador_datapath: RTL and testbench
=======================================

// Module: escalonador_datapath
// PURPOSE
//  Round-robin scheduler sharing one datapath/controle pair among N requesters.
//  Captures the winner's operand, pulses inicio to the controller, and waits for
//  its done. It then returns the datapath result to the winner with a one-cycle ack.
//  A watchdog aborts a transaction the controller never completes.
//  Sits between client blocks and the controle FSM + datapath.
// PARAMETERS
//  N        4   number of requesters (2..8)
//  W        8   operand/result width in bits
//  TIMEOUT  16  max cycles in WAIT before abort (>= 12; controller needs 10)
// PORTS
//  ck       in   1    clock, rising edge
//  rst      in   1    asynchronous reset, active-high
//  req      in   N    level request per requester
//  x_in     in   N*W  operands; slice k = x_in[k*W +: W]
//  gnt      out  N    one-hot grant, held for whole transaction
//  ack      out  N    one-cycle pulse to granted requester when result valid
//  err      out  1    with ack: 1 = transaction aborted by watchdog
//  result   out  W    result; valid in ack cycle, held until next capture
//  x_out    out  W    operand to datapath, stable GRANT..RESP
//  inicio   out  1    one-cycle start pulse to controller
//  ctrl_rst out  1    one-cycle reset to controller on abort
//  done     in   1    controller completion
//  s_in     in   W    datapath result, sampled when done=1
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; gnt, ack, err, inicio, ctrl_rst = 0.
//    result, x_out = 0; priority pointer ptr = 0; watchdog cnt = 0.
//  - FSM states: IDLE, GRANT, WAIT, RESP, ABORT. All outputs are registered.
//  - IDLE: if req != 0, pick the first set bit scanning ptr, ptr+1, .. mod N.
//    Set gnt[k] and x_out = x_in slice k, then go to GRANT. Otherwise stay.
//  - GRANT (1 cycle): inicio=1; cnt=0; go to WAIT. Any done seen here is ignored.
//  - WAIT: cnt++ each cycle.
//    If done=1: result = s_in, err=0, go to RESP.
//    Else if cnt == TIMEOUT-1: go to ABORT.
//    done and timeout in the same cycle: done wins.
//  - ABORT (1 cycle): ctrl_rst=1; result keeps its old value; go to RESP with err=1.
//  - RESP (1 cycle): ack[k]=1; ptr = (k+1) mod N; gnt cleared on exit; go to IDLE.
//  - Latency: grant at edge E, inicio high in E+1, ack one cycle after done sampled.
//    Minimum idle-to-idle time is controller latency + 3 cycles.
//  - req is level-sensitive. Dropping req after grant does not cancel; ack still pulses.
//    req still high after ack = new request at the rotated priority.
//  - No back-to-back grant: at least one IDLE cycle between transactions.
//  - x_in changes after GRANT do not affect x_out.
//  - ptr wraps N-1 -> 0. N not a power of 2: pointer arithmetic is explicit mod N.
//  - Reset mid-transaction: no ack is issued; the controller is reset by rst itself.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE=0..ABORT=4, 3-bit), controller
//    handshake widths, default W and TIMEOUT.
//  - One combinational sub-module: arbitro_rr (req, ptr -> one-hot winner + index).
//    It is reusable by other shared-resource schedulers.
//  - The top holds the FSM, the pointer, the watchdog counter ($clog2(TIMEOUT) bits)
//    and the capture regs.
// TESTING
//  1. Single request: req=0001, x_in[0]=8'h05, done after 9 cycles with s_in=8'h2A.
//     -> gnt=0001, one inicio, x_out=05, ack=0001 one cycle later, result=2A, err=0.
//  2. Fairness: req=1111 held high. Acks occur in order 0001,0010,0100,1000,0001.
//     ptr wraps correctly.
//  3. Timeout: done never asserted. -> ctrl_rst pulse at cycle TIMEOUT after inicio.
//     Then ack + err=1; result unchanged.
//  4. done coincident with last watchdog cycle -> normal completion, err=0.
//     No ctrl_rst.
//  5. rst asserted in WAIT -> all outputs 0 asynchronously, ptr=0, no ack.
//     Next req=0100 is granted normally.
//  6. Requester drops req and changes x_in during WAIT -> x_out unchanged.
//     ack still delivered to that requester.

Source files
------------

// File: rtl/escalonador_datapath_pkg.sv
// Shared definitions for the datapath scheduler: FSM state encoding, controller
// handshake widths and default sizing parameters.
package escalonador_datapath_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGrant = 3'd1,
    StWait  = 3'd2,
    StResp  = 3'd3,
    StAbort = 3'd4
  } estado_e;

  // Controller handshake: single-bit start, done and local reset.
  localparam int unsigned CtrlStartW = 1;
  localparam int unsigned CtrlDoneW  = 1;
  localparam int unsigned CtrlRstW   = 1;

  localparam int unsigned DefaultN       = 4;
  localparam int unsigned DefaultW       = 8;
  localparam int unsigned DefaultTimeout = 16;

endpackage

// File: rtl/escalonador_datapath_arbitro_rr.sv
// arbitro_rr: combinational round-robin arbiter.
//   req_i   : N request lines
//   ptr_i   : index of the highest-priority requester
//   gnt_o   : one-hot winner (all zero when no request)
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
// Scans ptr_i, ptr_i+1, .. wrapping explicitly mod N so N need not be a power of 2.
module arbitro_rr #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned      j;
  logic [IdxW-1:0]  jx;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    jx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      jx = IdxW'(j);
      if (!valid_o && req_i[jx]) begin
        valid_o   = 1'b1;
        gnt_o[jx] = 1'b1;
        idx_o     = jx;
      end
    end
  end

endmodule

// File: rtl/escalonador_datapath.sv
// escalonador_datapath: round-robin scheduler sharing one controller + datapath
// among N requesters, with a watchdog that aborts stalled transactions.
//   ck, rst        : clock (rising edge), asynchronous active-high reset
//   req, x_in      : per-requester level request and operand (slice k = x_in[k*W +: W])
//   gnt, ack, err  : one-hot grant, one-cycle ack pulse, abort flag valid with ack
//   result         : last datapath result, held until next capture
//   x_out, inicio  : operand and start pulse to the controller/datapath
//   ctrl_rst       : one-cycle controller reset on watchdog abort
//   done, s_in     : controller completion and datapath result
// All outputs are registered; each is asserted on entry to the state it belongs to,
// so e.g. inicio is high during GRANT and ack is high during RESP.
module escalonador_datapath
  import escalonador_datapath_pkg::*;
#(
  parameter int unsigned N       = DefaultN,
  parameter int unsigned W       = DefaultW,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic           ck,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] x_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic           err,
  output logic [W-1:0]   result,
  output logic [W-1:0]   x_out,
  output logic           inicio,
  output logic           ctrl_rst,
  input  logic           done,
  input  logic [W-1:0]   s_in
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT);

  estado_e         state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            err_q, err_d;
  logic            inicio_q, inicio_d;
  logic            ctrl_rst_q, ctrl_rst_d;
  logic [W-1:0]    result_q, result_d;
  logic [W-1:0]    x_out_q, x_out_d;

  logic [N-1:0]    win_gnt;
  logic [IdxW-1:0] win_idx;
  logic            win_valid;
  logic [W-1:0]    x_sel;

  arbitro_rr #(
    .N    (N),
    .IdxW (IdxW)
  ) u_arbitro (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Operand mux with constant slice indices.
  always_comb begin
    x_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (win_idx == IdxW'(k)) x_sel = x_in[k*W +: W];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    err_d      = err_q;
    inicio_d   = 1'b0;
    ctrl_rst_d = 1'b0;
    result_d   = result_q;
    x_out_d    = x_out_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          gnt_d    = win_gnt;
          idx_d    = win_idx;
          x_out_d  = x_sel;
          inicio_d = 1'b1;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        // done is not looked at here: the controller has not started yet.
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          result_d = s_in;
          err_d    = 1'b0;
          ack_d    = gnt_q;
          state_d  = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          ctrl_rst_d = 1'b1;
          state_d    = StAbort;
        end
      end
      StAbort: begin
        err_d   = 1'b1;
        ack_d   = gnt_q;
        state_d = StResp;
      end
      StResp: begin
        ptr_d   = (idx_q == IdxW'(N - 1)) ? '0 : idx_q + 1'b1;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      inicio_q   <= 1'b0;
      ctrl_rst_q <= 1'b0;
      result_q   <= '0;
      x_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      inicio_q   <= inicio_d;
      ctrl_rst_q <= ctrl_rst_d;
      result_q   <= result_d;
      x_out_q    <= x_out_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign result   = result_q;
  assign x_out    = x_out_q;
  assign inicio   = inicio_q;
  assign ctrl_rst = ctrl_rst_q;

endmodule

// File: tb/tb_escalonador_datapath.sv
module tb_escalonador_datapath;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 16;

  logic           ck;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] x_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           err;
  logic [W-1:0]   result;
  logic [W-1:0]   x_out;
  logic           inicio;
  logic           ctrl_rst;
  logic           done;
  logic [W-1:0]   s_in;

  typedef struct {
    logic [N-1:0] ack;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] model_res;
  int n_checks;
  int n_pass;

  escalonador_datapath #(
    .N       (N),
    .W       (W),
    .TIMEOUT (T)
  ) dut (
    .ck       (ck),
    .rst      (rst),
    .req      (req),
    .x_in     (x_in),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .result   (result),
    .x_out    (x_out),
    .inicio   (inicio),
    .ctrl_rst (ctrl_rst),
    .done     (done),
    .s_in     (s_in)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_res = '0;
    tick();
  endtask

  // One transaction: wait for grant, act as controller, check ack via scoreboard.
  task automatic do_txn(input logic [N-1:0] exp_gnt, input logic [W-1:0] exp_x,
                        input int delay, input logic [W-1:0] s, input bit give_done,
                        input bit drop, input logic [N-1:0] req_after);
    int k;
    exp_t e;
    k = 0;
    while (gnt === '0 && k < 40) begin
      tick();
      k++;
    end
    n_checks++;
    if (gnt !== exp_gnt) begin
      $display("FAIL grant: got %b expected %b", gnt, exp_gnt);
      return;
    end else n_pass++;
    n_checks++;
    if (x_out !== exp_x) $display("FAIL x_out_grant: got %h expected %h", x_out, exp_x);
    else n_pass++;
    n_checks++;
    if (inicio !== 1'b1) $display("FAIL inicio_high: got %b expected 1", inicio);
    else n_pass++;
    tick();
    n_checks++;
    if (inicio !== 1'b0) $display("FAIL inicio_pulse: got %b expected 0", inicio);
    else n_pass++;
    if (drop) begin
      req  = '0;
      x_in = ~x_in;
    end
    if (give_done) begin
      repeat (delay) tick();
      done = 1'b1;
      s_in = s;
      model_res = s;
      sb.push_back('{ack: exp_gnt, res: s, err: 1'b0});
      tick();
      done = 1'b0;
      s_in = '0;
    end else begin
      sb.push_back('{ack: exp_gnt, res: model_res, err: 1'b1});
      k = 0;
      while (ctrl_rst !== 1'b1 && k < 3 * T) begin
        tick();
        k++;
      end
      n_checks++;
      if (k !== T) $display("FAIL abort_latency: got %0d expected %0d", k, T);
      else n_pass++;
      tick();
    end
    e = sb.pop_front();
    n_checks++;
    if (ack !== e.ack) $display("FAIL ack: got %b expected %b", ack, e.ack);
    else n_pass++;
    n_checks++;
    if (result !== e.res) $display("FAIL result: got %h expected %h", result, e.res);
    else n_pass++;
    n_checks++;
    if (err !== e.err) $display("FAIL err: got %b expected %b", err, e.err);
    else n_pass++;
    n_checks++;
    if (ctrl_rst !== 1'b0) $display("FAIL ctrl_rst_resp: got %b expected 0", ctrl_rst);
    else n_pass++;
    n_checks++;
    if (x_out !== exp_x) $display("FAIL x_out_resp: got %h expected %h", x_out, exp_x);
    else n_pass++;
    req = req_after;
    tick();
    n_checks++;
    if ({ack, gnt} !== '0) $display("FAIL idle_after: got ack=%b gnt=%b expected 0", ack, gnt);
    else n_pass++;
  endtask

  task automatic test_reset;
    req  = '0;
    x_in = '0;
    done = 1'b0;
    s_in = '0;
    rst  = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({gnt, ack, err, inicio, ctrl_rst, result, x_out} !== '0)
      $display("FAIL reset_outputs: got gnt=%b ack=%b err=%b ini=%b crst=%b res=%h x=%h expected 0",
               gnt, ack, err, inicio, ctrl_rst, result, x_out);
    else n_pass++;
    rst = 1'b0;
    model_res = '0;
    tick();
    tick();
    n_checks++;
    if ({gnt, inicio} !== '0) $display("FAIL idle_no_req: got gnt=%b ini=%b expected 0", gnt, inicio);
    else n_pass++;
  endtask

  task automatic test_single;
    x_in = '0;
    x_in[0*W +: W] = 8'h05;
    req = 4'b0001;
    do_txn(4'b0001, 8'h05, 9, 8'h2A, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_fairness;
    logic [N-1:0] eg;
    apply_reset();
    x_in = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      eg = 4'b0001 << (i % 4);
      do_txn(eg, x_in[(i % 4)*W +: W], 2 + i, 8'h80 + 8'(i), 1'b1, 1'b0,
             (i == 4) ? 4'b0000 : 4'b1111);
    end
  endtask

  task automatic test_timeout;
    x_in = {8'h00, 8'h00, 8'h3C, 8'h00};
    req  = 4'b0010;
    do_txn(4'b0010, 8'h3C, 0, 8'h00, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_done_last;
    x_in = {8'h00, 8'h9D, 8'h00, 8'h00};
    req  = 4'b0100;
    do_txn(4'b0100, 8'h9D, T - 1, 8'h5A, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_reset_wait;
    int k;
    bit seen;
    x_in = {8'h00, 8'h00, 8'h61, 8'h00};
    req  = 4'b0010;
    k = 0;
    while (gnt === '0 && k < 40) begin
      tick();
      k++;
    end
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, ack, err, inicio, ctrl_rst, result, x_out} !== '0)
      $display("FAIL async_reset: got gnt=%b ack=%b err=%b ini=%b crst=%b res=%h x=%h expected 0",
               gnt, ack, err, inicio, ctrl_rst, result, x_out);
    else n_pass++;
    req = '0;
    model_res = '0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack !== '0 || gnt !== '0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL no_ack_after_reset: got 1 expected 0");
    else n_pass++;
    // ptr back at 0: all-ones request must go to requester 0.
    x_in = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    req  = 4'b1111;
    do_txn(4'b0001, 8'hA1, 3, 8'h17, 1'b1, 1'b0, 4'b0100);
    do_txn(4'b0100, 8'hC3, 5, 8'h18, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_drop;
    x_in = {8'h77, 8'h00, 8'h00, 8'h00};
    req  = 4'b1000;
    do_txn(4'b1000, 8'h77, 4, 8'hC3, 1'b1, 1'b1, 4'b0000);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_done_last();
    test_reset_wait();
    test_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
